gift128_crypt_core: RTL
=======================

# gift128_crypt_core

Parametrised GIFT-128 block cipher core doing both encryption and decryption with a selectable number of unrolled rounds per clock. It extends the single-round decrypt-only datapath with a mode input, a one-time key pre-expansion so decryption can start from the final round key, a result-valid strobe and an asynchronous reset. It sits between the host register interface and the mode-of-operation logic. Host writes a key once, then streams blocks one at a time.

## Interface
- ROUNDS_PER_CYCLE, 1: GIFT rounds computed per clock; legal values 1, 2, 4, 5, 8, 10, 20, 40 (must divide 40); other values are an elaboration error.
- N (localparam), 40/ROUNDS_PER_CYCLE: cycles per block and per key expansion.

- inClk  in  1  clock, rising edge.
- inRst  in  1  reset, asynchronous, active-high.
- inKeyWr  in  1  key write strobe, sampled on inClk.
- inKeyData  in  128  master key, valid with inKeyWr.
- inDataWr  in  1  block write strobe.
- inDataData  in  128  plaintext or ciphertext, valid with inDataWr.
- inMode  in  1  0 = encrypt, 1 = decrypt; sampled with inDataWr.
- outData  out  128  last result; held until the next result.
- outValid  out  1  one-cycle pulse when outData is updated.
- outBusy  out  1  high while key expansion or a block is in progress.
- outKeyReady  out  1  high once a key has been fully expanded.

## Operation
- States: IDLE, KEYEXP, RUN. Round counter is 0..N-1.
- IDLE + inKeyWr: store inKeyData as the master key, clear outKeyReady, go to KEYEXP.
- KEYEXP: step the key schedule and the 6-bit round-constant LFSR forward ROUNDS_PER_CYCLE rounds per cycle for N cycles. Store the round-40 key state and the final constant as the decrypt start point, set outKeyReady, return to IDLE.
- IDLE + inDataWr + outKeyReady: load the state register, latch inMode, go to RUN.
  - Encrypt starts from the master key and constant 0x00 and steps forward: SubCells, PermBits, AddRoundKey/constant.
  - Decrypt starts from the stored final key and constant and runs the inverse rounds: AddRoundKey/constant, inverse PermBits, inverse SubCells. Key schedule and LFSR step backward.
- RUN: after N cycles, write the state to outData, pulse outValid, return to IDLE.
- inDataWr while outKeyReady=0: ignored; no state change, no outValid.
- Any write while outBusy=1: ignored. In-flight operation is unaffected.
- inKeyWr and inDataWr together in IDLE: key wins; the data write is dropped.
- Master key and final key registers stay valid across blocks. Only inKeyWr or inRst invalidate them.

## Timing
- Reset values: outData=0, outValid=0, outBusy=0, outKeyReady=0, state=IDLE, counter=0, key registers=0.
- Write accepted at edge E0: outBusy is high from E0 through edge E0+N.
- Block: at edge E0+N, outData is loaded, outValid=1 and outBusy=0 for that cycle. A new inDataWr is accepted at edge E0+N+1 at the earliest, giving throughput of one block per N+1 cycles.
- Key expansion: at edge E0+N, outKeyReady=1 and outBusy=0. No outValid pulse.
- inRst mid-operation: immediate return to reset values. Partial result and key are discarded, and outKeyReady stays 0 until a new key is written.
- Round/key/constant logic is combinational per cycle. The only sequential elements are the state, key, constant, counter and output registers.

## Test plan
- Reset then inDataWr without a key: no outValid, outBusy stays 0, outData=0.
- Key K=0x000102030405060708090A0B0C0D0E0F, then encrypt P=0: outKeyReady rises exactly N cycles after the write. outValid comes N cycles after the data write, and outData equals the golden C model ciphertext C. Run this for ROUNDS_PER_CYCLE=1, 4 and 40.
- Decrypt C with the same key: outData=0, with identical latency. Back-to-back blocks written at the first idle cycle give an outValid every N+1 cycles.
- Write inDataWr and inKeyWr while outBusy: the running result is unchanged and no extra outValid appears.
- Simultaneous inKeyWr and inDataWr in IDLE: key expansion only, no outValid, new key used afterwards.
- Assert inRst at cycle N/2 of RUN: all outputs return to 0 asynchronously, and a following inDataWr is ignored until a key is reloaded.

Source files
------------

// File: rtl/gift128_crypt_core.sv
// GIFT-128 block cipher core: encrypt and decrypt with ROUNDS_PER_CYCLE unrolled rounds per clock.
// The key is expanded once up front so decryption can start from the round-40 key state.
module gift128_crypt_core #(
   parameter int ROUNDS_PER_CYCLE = 1
) (
   input  logic         inClk,
   input  logic         inRst,
   input  logic         inKeyWr,
   input  logic [127:0] inKeyData,
   input  logic         inDataWr,
   input  logic [127:0] inDataData,
   input  logic         inMode,
   output logic [127:0] outData,
   output logic         outValid,
   output logic         outBusy,
   output logic         outKeyReady
);
   localparam int N = 40 / ROUNDS_PER_CYCLE;
   localparam logic [5:0] LAST = 6'(N - 1);
   localparam logic [63:0] SBOX     = 64'he8057bd293f6c4a1;
   localparam logic [63:0] SBOX_INV = 64'h5f93a17eb4c2680d;

   generate
      if (ROUNDS_PER_CYCLE < 1 || (40 % ROUNDS_PER_CYCLE) != 0) begin : g_bad_param
         $error("ROUNDS_PER_CYCLE must divide 40");
      end
   endgenerate

   function automatic logic [127:0] sub_cells(input logic [127:0] s, input bit inv);
      logic [127:0] t;
      t = '0;
      for (int i = 0; i < 32; i++)
         t[4*i +: 4] = inv ? SBOX_INV[{s[4*i +: 4], 2'b00} +: 4] : SBOX[{s[4*i +: 4], 2'b00} +: 4];
      return t;
   endfunction

   function automatic int perm_idx(input int i);
      return 4 * (i / 16) + 32 * ((3 * ((i % 16) / 4) + (i % 4)) % 4) + (i % 4);
   endfunction

   function automatic logic [127:0] perm_bits(input logic [127:0] s);
      logic [127:0] t;
      t = '0;
      for (int i = 0; i < 128; i++) t[perm_idx(i)] = s[i];
      return t;
   endfunction

   function automatic logic [127:0] perm_bits_inv(input logic [127:0] s);
      logic [127:0] t;
      t = '0;
      for (int i = 0; i < 128; i++) t[i] = s[perm_idx(i)];
      return t;
   endfunction

   // U = k5||k4 lands on bit 2 of each nibble, V = k1||k0 on bit 1; constant on bits 23..3 plus bit 127
   function automatic logic [127:0] rk_mask(input logic [127:0] k, input logic [5:0] c);
      logic [127:0] m;
      m = '0;
      for (int i = 0; i < 32; i++) begin
         m[4*i+2] = k[64+i];
         m[4*i+1] = k[i];
      end
      m[127] = 1'b1;
      m[23]  = c[5];
      m[19]  = c[4];
      m[15]  = c[3];
      m[11]  = c[2];
      m[7]   = c[1];
      m[3]   = c[0];
      return m;
   endfunction

   function automatic logic [127:0] key_fwd(input logic [127:0] k);
      return {k[17:16], k[31:18], k[11:0], k[15:12], k[127:32]};
   endfunction

   function automatic logic [127:0] key_bwd(input logic [127:0] k);
      return {k[95:0], k[125:112], k[127:126], k[99:96], k[111:100]};
   endfunction

   function automatic logic [5:0] lfsr_fwd(input logic [5:0] c);
      return {c[4:0], c[5] ^ c[4] ^ 1'b1};
   endfunction

   function automatic logic [5:0] lfsr_bwd(input logic [5:0] c);
      return {c[0] ^ c[5] ^ 1'b1, c[5:1]};
   endfunction

   typedef enum logic [1:0] {IDLE, KEYEXP, RUN} state_t;

   state_t       r_fsm;
   logic [127:0] r_state;
   logic [127:0] r_key;
   logic [127:0] r_master_key;
   logic [127:0] r_final_key;
   logic [127:0] r_data;
   logic [5:0]   r_const;
   logic [5:0]   r_final_const;
   logic [5:0]   r_cnt;
   logic         r_mode;
   logic         r_valid;
   logic         r_busy;
   logic         r_key_ready;

   logic [127:0] w_enc_s [0:ROUNDS_PER_CYCLE];
   logic [127:0] w_enc_k [0:ROUNDS_PER_CYCLE];
   logic [5:0]   w_enc_c [0:ROUNDS_PER_CYCLE];
   logic [127:0] w_dec_s [0:ROUNDS_PER_CYCLE];
   logic [127:0] w_dec_k [0:ROUNDS_PER_CYCLE];
   logic [5:0]   w_dec_c [0:ROUNDS_PER_CYCLE];
   logic [127:0] w_run_s;
   logic [127:0] w_run_k;
   logic [5:0]   w_run_c;

   assign w_enc_s[0] = r_state;
   assign w_enc_k[0] = r_key;
   assign w_enc_c[0] = r_const;
   assign w_dec_s[0] = r_state;
   assign w_dec_k[0] = r_key;
   assign w_dec_c[0] = r_const;

   // Forward rounds use the constant after stepping; inverse rounds step the key back before use
   genvar gi;
   generate
      for (gi = 0; gi < ROUNDS_PER_CYCLE; gi++) begin : g_round
         assign w_enc_c[gi+1] = lfsr_fwd(w_enc_c[gi]);
         assign w_enc_s[gi+1] = perm_bits(sub_cells(w_enc_s[gi], 1'b0)) ^ rk_mask(w_enc_k[gi], w_enc_c[gi+1]);
         assign w_enc_k[gi+1] = key_fwd(w_enc_k[gi]);
         assign w_dec_k[gi+1] = key_bwd(w_dec_k[gi]);
         assign w_dec_s[gi+1] = sub_cells(perm_bits_inv(w_dec_s[gi] ^ rk_mask(w_dec_k[gi+1], w_dec_c[gi])), 1'b1);
         assign w_dec_c[gi+1] = lfsr_bwd(w_dec_c[gi]);
      end
   endgenerate

   assign w_run_s = r_mode ? w_dec_s[ROUNDS_PER_CYCLE] : w_enc_s[ROUNDS_PER_CYCLE];
   assign w_run_k = r_mode ? w_dec_k[ROUNDS_PER_CYCLE] : w_enc_k[ROUNDS_PER_CYCLE];
   assign w_run_c = r_mode ? w_dec_c[ROUNDS_PER_CYCLE] : w_enc_c[ROUNDS_PER_CYCLE];

   always_ff @(posedge inClk or posedge inRst) begin
      if (inRst) begin
         r_fsm         <= IDLE;
         r_state       <= '0;
         r_key         <= '0;
         r_master_key  <= '0;
         r_final_key   <= '0;
         r_data        <= '0;
         r_const       <= '0;
         r_final_const <= '0;
         r_cnt         <= '0;
         r_mode        <= 1'b0;
         r_valid       <= 1'b0;
         r_busy        <= 1'b0;
         r_key_ready   <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         case (r_fsm)
            IDLE: begin
               if (inKeyWr) begin
                  r_master_key <= inKeyData;
                  r_key        <= inKeyData;
                  r_const      <= '0;
                  r_cnt        <= '0;
                  r_key_ready  <= 1'b0;
                  r_busy       <= 1'b1;
                  r_fsm        <= KEYEXP;
               end else if (inDataWr && r_key_ready) begin
                  r_state <= inDataData;
                  r_mode  <= inMode;
                  r_key   <= inMode ? r_final_key : r_master_key;
                  r_const <= inMode ? r_final_const : 6'h00;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_fsm   <= RUN;
               end
            end
            KEYEXP: begin
               r_key   <= w_enc_k[ROUNDS_PER_CYCLE];
               r_const <= w_enc_c[ROUNDS_PER_CYCLE];
               if (r_cnt == LAST) begin
                  r_final_key   <= w_enc_k[ROUNDS_PER_CYCLE];
                  r_final_const <= w_enc_c[ROUNDS_PER_CYCLE];
                  r_key_ready   <= 1'b1;
                  r_busy        <= 1'b0;
                  r_fsm         <= IDLE;
               end else begin
                  r_cnt <= r_cnt + 6'd1;
               end
            end
            RUN: begin
               r_state <= w_run_s;
               r_key   <= w_run_k;
               r_const <= w_run_c;
               if (r_cnt == LAST) begin
                  r_data  <= w_run_s;
                  r_valid <= 1'b1;
                  r_busy  <= 1'b0;
                  r_fsm   <= IDLE;
               end else begin
                  r_cnt <= r_cnt + 6'd1;
               end
            end
            default: r_fsm <= IDLE;
         endcase
      end
   end

   assign outData     = r_data;
   assign outValid    = r_valid;
   assign outBusy     = r_busy;
   assign outKeyReady = r_key_ready;

endmodule
